// File: rtl/rom_seq_reader.sv
// Streams a run of consecutive ROM words through a 2-entry skid buffer with valid/ready output.
// Optional checksum outputs are enabled by defining ROM_SEQ_READER_CHKSUM_EN.
module rom_seq_reader #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 4
) (
  input  logic          inclk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] count,
  input  logic          loop,
  input  logic          stop,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done
`ifdef ROM_SEQ_READER_CHKSUM_EN
  ,
  output logic [DW-1:0] chksum,
  output logic          chk_valid
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  localparam logic [AW:0]   REM_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, base_q, base_d;
  logic [AW:0]   rem_q, rem_d, len_q, len_d;
  logic          loop_q, loop_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    occ_q, occ_d;
  logic [DW-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          pop, push, issue, loop_eff;
  logic [2:0]    credit;

  always_comb begin
    pop      = valid_q & dout_ready;
    push     = inflight_q;
    loop_eff = loop_q & ~stop;
    credit   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue    = (state_q == S_RUN) && (rem_q != '0) && (credit <= 3'd1);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    base_d     = base_q;
    rem_d      = rem_q;
    len_d      = len_q;
    loop_d     = loop_q;
    inflight_d = issue;
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Head register always holds the oldest word; entry 1 only fills when the head is occupied.
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = rom_q;
        else               buf1_d = rom_q;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = rom_q;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rom_q;
        end
      end
      default: ;
    endcase
    valid_d = (occ_d != 2'd0);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ptr_d   = base_addr;
          base_d  = base_addr;
          len_d   = {1'b0, count} + REM_ONE;
          rem_d   = {1'b0, count} + REM_ONE;
          loop_d  = loop;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        loop_d = loop_eff;
        if (issue) begin
          ptr_d = ptr_q + PTR_ONE;
          rem_d = rem_q - REM_ONE;
          // Reload on the edge that issues the last word so a looped run has no bubble.
          if (rem_q == REM_ONE) begin
            if (loop_eff) begin
              ptr_d = base_q;
              rem_d = len_q;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end else if (rem_q == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        loop_d = loop_eff;
        if (occ_d == 2'd0 && !inflight_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      base_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      base_q     <= base_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr   = ptr_q;
  assign dout       = buf0_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

  a_no_overflow: assert property (@(posedge inclk) disable iff (rst)
    !(push && !pop && occ_q == 2'd2));

`ifdef ROM_SEQ_READER_CHKSUM_EN
  logic [DW-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (state_q == S_IDLE && start) chk_d = '0;
    else if (pop)                   chk_d = chk_q ^ buf0_q;
  end

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign chksum    = chk_q;
  assign chk_valid = done_q;
`endif

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed bench for rom_seq_reader: a word-stream model checks every output cycle,
// plus hand-computed literal checks of latency, wrap, backpressure, loop/stop and reset.
module tb_rom_seq_reader;

  logic       inclk;
  logic       rst;
  logic       start;
  logic [3:0] base_addr;
  logic [3:0] count;
  logic       loop;
  logic       stop;
  logic [3:0] rom_addr;
  logic [3:0] rom_q;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       done;
`ifdef ROM_SEQ_READER_CHKSUM_EN
  logic [3:0] chksum;
  logic       chk_valid;
`endif

  rom_seq_reader #(.AW(4), .DW(4)) dut (
    .inclk      (inclk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .loop       (loop),
    .stop       (stop),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
`ifdef ROM_SEQ_READER_CHKSUM_EN
    ,
    .chksum     (chksum),
    .chk_valid  (chk_valid)
`endif
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  // ROM[a] = ~a, address registered on the clock edge
  always @(posedge inclk) rom_q <= ~rom_addr;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic wait_done(input string name, input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask

  // Expected word stream: run of len words starting at base, replayed for looped runs
  int         loop_total = 0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [3:0] m_base = '0;
  int         m_len = 0;
  int         m_idx = 0;
  int         m_popped = 0;
  int         m_total = 0;
  logic       hold_v = 1'b0;
  logic [3:0] hold_d = '0;

  always @(negedge inclk) begin
    logic       fin;
    logic       accept;
    logic [3:0] a;
    logic [3:0] e;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      hold_v = 1'b0;
    end else begin
      fin = 1'b0;
      chk("done", done, m_done);
      chk("busy", busy, m_busy);
      if (hold_v) chk("hold", dout, hold_d);
      if (!m_busy) begin
        chk("idle_valid", dout_valid, 0);
      end else if (dout_valid && dout_ready) begin
        a = m_base + 4'(m_idx);
        e = ~a;
        chk("word", dout, e);
        m_idx = (m_idx + 1 == m_len) ? 0 : m_idx + 1;
        m_popped++;
        fin = (m_popped == m_total);
      end
      hold_v = dout_valid && !dout_ready;
      hold_d = dout;
      accept = start && !m_busy;
      m_done = fin;
      if (fin) m_busy = 1'b0;
      if (accept) begin
        m_busy   = 1'b1;
        m_base   = base_addr;
        m_len    = int'(count) + 1;
        m_idx    = 0;
        m_popped = 0;
        m_total  = loop ? loop_total : int'(count) + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; loop = 1'b0;
    stop = 1'b0; dout_ready = 1'b1;
    repeat (2) @(posedge inclk);
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // stop while idle does nothing
    stop = 1'b1; tick(); stop = 1'b0; tick();
    chk("idle_stop_busy", busy, 0);

    // basic run: base 3, 3 words -> C,B,A
    base_addr = 4'h3; count = 4'd2; loop = 1'b0; start = 1'b1;
    tick(); start = 1'b0;                       // E0
    chk("bas_busy", busy, 1);
    tick(); chk("bas_lat_v0", dout_valid, 0);   // E1
    tick(); chk("bas_first_v", dout_valid, 1);  // E2
    chk("bas_w0", dout, 4'hC);
    tick(); chk("bas_w1", dout, 4'hB);
    tick(); chk("bas_w2", dout, 4'hA);
    tick(); chk("bas_done", done, 1);           // E5
    chk("bas_busy_end", busy, 0);
    tick(); chk("bas_done_pulse", done, 0);
    tick();

    // wrap: base E, 4 words -> addresses E,F,0,1
    base_addr = 4'hE; count = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    chk("wrap_a0", rom_addr, 4'hE);
    tick(); chk("wrap_a1", rom_addr, 4'hF);
    tick(); chk("wrap_a2", rom_addr, 4'h0);
    chk("wrap_w0", dout, 4'h1);
    tick(); chk("wrap_a3", rom_addr, 4'h1);
    wait_done("wrap_done_seen", 20, n);
    tick(); tick();

    // backpressure: base 0, 8 words, consumer stalled 6 cycles after first valid
    dout_ready = 1'b0;
    base_addr = 4'h0; count = 4'd7; start = 1'b1;
    tick(); start = 1'b0;                       // E0
    tick();                                     // E1
    tick();                                     // E2
    chk("bp_first_v", dout_valid, 1);
    base_addr = 4'h8; start = 1'b1;             // ignored: busy
    tick(); start = 1'b0;                       // E3
    repeat (5) tick();                          // E8
    chk("bp_stall_addr", rom_addr, 4'h2);
    chk("bp_head", dout, 4'hF);
    chk("bp_valid", dout_valid, 1);
    dout_ready = 1'b1;
    wait_done("bp_done_seen", 40, n);
    tick(); tick();

    // loop: base 5, 2 words, stop during the 3rd pass -> 6 words total
    loop_total = 6;
    base_addr = 4'h5; count = 4'd1; loop = 1'b1; start = 1'b1;
    tick(); start = 1'b0; loop = 1'b0;          // E0
    tick();                                     // E1
    tick(); chk("loop_w0", dout, 4'hA);         // E2
    tick(); chk("loop_w1", dout, 4'h9);         // E3
    tick(); chk("loop_w2", dout, 4'hA);         // E4
    stop = 1'b1;
    tick(); stop = 1'b0;                        // E5
    wait_done("loop_done_seen", 20, n);
    chk("loop_done_lat", n, 3);
    tick(); tick();
    chk("loop_no_4th", dout_valid, 0);

    // reset mid-run after 2 words, then a normal run
    base_addr = 4'h0; count = 4'd7; start = 1'b1;
    tick(); start = 1'b0;                       // E0
    repeat (4) tick();                          // E4: two words popped
    chk("mid_head", dout, 4'hD);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_done", done, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("mid_no_done", done, 0);
    base_addr = 4'h2; count = 4'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("post_rst_w0", dout, 4'hD);
    wait_done("post_rst_done_seen", 20, n);
    tick(); tick();

`ifdef ROM_SEQ_READER_CHKSUM_EN
    base_addr = 4'h0; count = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    wait_done("cks_done_seen", 20, n);
    chk("cks_valid", chk_valid, 1);
    chk("cks_value", chksum, 0);
    tick();
    chk("cks_valid_pulse", chk_valid, 0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
